// File: rtl/instr_encoder_pkg.sv
// Shared MIPS ISA constants for the program loader: mnemonic codes, opcodes, funct codes,
// instruction classes and loader FSM states.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_R       = 2'd0,
        CLS_I       = 2'd1,
        CLS_J       = 2'd2,
        CLS_ILLEGAL = 2'd3
    } iclass_t;

    // Mnemonic codes: R-type 0..14, I-type 15..25, J-type 26..27, 28..31 illegal
    localparam logic [4:0] M_SLL   = 5'd0;
    localparam logic [4:0] M_SRL   = 5'd1;
    localparam logic [4:0] M_SRA   = 5'd2;
    localparam logic [4:0] M_SLLV  = 5'd3;
    localparam logic [4:0] M_SRLV  = 5'd4;
    localparam logic [4:0] M_SRAV  = 5'd5;
    localparam logic [4:0] M_JR    = 5'd6;
    localparam logic [4:0] M_ADD   = 5'd7;
    localparam logic [4:0] M_SUB   = 5'd8;
    localparam logic [4:0] M_AND   = 5'd9;
    localparam logic [4:0] M_OR    = 5'd10;
    localparam logic [4:0] M_XOR   = 5'd11;
    localparam logic [4:0] M_NOR   = 5'd12;
    localparam logic [4:0] M_SLT   = 5'd13;
    localparam logic [4:0] M_SLTU  = 5'd14;
    localparam logic [4:0] M_BEQ   = 5'd15;
    localparam logic [4:0] M_BNE   = 5'd16;
    localparam logic [4:0] M_ADDI  = 5'd17;
    localparam logic [4:0] M_SLTI  = 5'd18;
    localparam logic [4:0] M_SLTIU = 5'd19;
    localparam logic [4:0] M_ANDI  = 5'd20;
    localparam logic [4:0] M_ORI   = 5'd21;
    localparam logic [4:0] M_XORI  = 5'd22;
    localparam logic [4:0] M_LUI   = 5'd23;
    localparam logic [4:0] M_LW    = 5'd24;
    localparam logic [4:0] M_SW    = 5'd25;
    localparam logic [4:0] M_J     = 5'd26;
    localparam logic [4:0] M_JAL   = 5'd27;

    localparam logic [4:0] M_R_LAST = M_SLTU;
    localparam logic [4:0] M_I_LAST = M_SW;
    localparam logic [4:0] M_J_LAST = M_JAL;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_SLLV = 6'd4;
    localparam logic [5:0] FN_SRLV = 6'd6;
    localparam logic [5:0] FN_SRAV = 6'd7;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    function automatic iclass_t mnem_class(input logic [4:0] m);
        if (m <= M_R_LAST)
            return CLS_R;
        else if (m <= M_I_LAST)
            return CLS_I;
        else if (m <= M_J_LAST)
            return CLS_J;
        else
            return CLS_ILLEGAL;
    endfunction

    // Immediate-shift forms carry the amount in shamt and leave rs unused
    function automatic logic is_shift_imm(input logic [4:0] m);
        return (m == M_SLL) || (m == M_SRL) || (m == M_SRA);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: symbolic mnemonic plus register/immediate fields to a 32-bit MIPS
// word, with unused fields forced to zero and an illegal flag for codes 28..31.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    logic [5:0] funct;
    logic [5:0] opcode;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic [4:0] shamt_f;

    always_comb begin
        funct = FN_SLL;
        case (mnem)
            M_SLL:   funct = FN_SLL;
            M_SRL:   funct = FN_SRL;
            M_SRA:   funct = FN_SRA;
            M_SLLV:  funct = FN_SLLV;
            M_SRLV:  funct = FN_SRLV;
            M_SRAV:  funct = FN_SRAV;
            M_JR:    funct = FN_JR;
            M_ADD:   funct = FN_ADD;
            M_SUB:   funct = FN_SUB;
            M_AND:   funct = FN_AND;
            M_OR:    funct = FN_OR;
            M_XOR:   funct = FN_XOR;
            M_NOR:   funct = FN_NOR;
            M_SLT:   funct = FN_SLT;
            M_SLTU:  funct = FN_SLTU;
            default: funct = FN_SLL;
        endcase
    end

    always_comb begin
        opcode = OP_RTYPE;
        case (mnem)
            M_BEQ:   opcode = OP_BEQ;
            M_BNE:   opcode = OP_BNE;
            M_ADDI:  opcode = OP_ADDI;
            M_SLTI:  opcode = OP_SLTI;
            M_SLTIU: opcode = OP_SLTIU;
            M_ANDI:  opcode = OP_ANDI;
            M_ORI:   opcode = OP_ORI;
            M_XORI:  opcode = OP_XORI;
            M_LUI:   opcode = OP_LUI;
            M_LW:    opcode = OP_LW;
            M_SW:    opcode = OP_SW;
            M_J:     opcode = OP_J;
            M_JAL:   opcode = OP_JAL;
            default: opcode = OP_RTYPE;
        endcase
    end

    // jr only names rs; immediate shifts and lui have no rs source
    always_comb begin
        rs_f    = (is_shift_imm(mnem) || mnem == M_LUI) ? 5'd0 : rs;
        rt_f    = (mnem == M_JR) ? 5'd0 : rt;
        rd_f    = (mnem == M_JR) ? 5'd0 : rd;
        shamt_f = is_shift_imm(mnem) ? shamt : 5'd0;
    end

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem_class(mnem))
            CLS_R:   word = {OP_RTYPE, rs_f, rt_f, rd_f, shamt_f, funct};
            CLS_I:   word = {opcode, rs_f, rt, imm};
            CLS_J:   word = {opcode, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader in front of instruction memory: encodes a stream of symbolic instructions
// and writes them to consecutive word addresses through a single registered output slot.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic              busy
);

    state_t      state;
    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic        write_done;

    instr_pack u_pack (
        .mnem    (mnem),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (word),
        .illegal (illegal)
    );

    // The slot can take a new word whenever it is empty or is being emptied this cycle
    assign in_ready   = (state == ST_RUN) && (!imem_we || imem_ready);
    assign accept     = in_valid && in_ready;
    assign write_done = imem_we && imem_ready;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (write_done) begin
                imem_we   <= 1'b0;
                imem_addr <= imem_addr + ADDR_W'(4);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        imem_addr <= base_addr & ~ADDR_W'(3);
                        err       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_wdata <= word;
                        end
                        if (in_last)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!imem_we || write_done) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed ISA vectors plus randomized programs
// scored against a table-driven encoding model and an address/ordering scoreboard.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [4:0]  mnem = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        imem_we;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        done;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    instr_encoder #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .mnem       (mnem),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Encoding tables indexed by mnemonic position within each class
    int funct_tab [15] = '{0, 2, 3, 4, 6, 7, 8, 32, 34, 36, 37, 38, 39, 42, 43};
    int op_tab    [13] = '{4, 5, 8, 10, 11, 12, 13, 14, 15, 35, 43, 2, 3};

    function automatic logic [31:0] ref_word(input int m, input int s, input int t, input int d,
                                             input int sh, input int im, input int tg);
        longint w;
        if (m <= 14) begin
            if (m <= 2) s = 0;
            else sh = 0;
            if (m == 6) begin
                t = 0; d = 0; sh = 0;
            end
            w = longint'(s) * 2097152 + longint'(t) * 65536 + longint'(d) * 2048
                + longint'(sh) * 64 + longint'(funct_tab[m]);
        end else if (m <= 25) begin
            if (m == 23) s = 0;
            w = longint'(op_tab[m - 15]) * 67108864 + longint'(s) * 2097152
                + longint'(t) * 65536 + longint'(im);
        end else begin
            w = longint'(op_tab[m - 15]) * 67108864 + longint'(tg);
        end
        return w[31:0];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Scoreboard state: model writes in order, optional literal vectors, err/done model
    logic [63:0] exp_q[$];
    logic [63:0] gold_q[$];
    logic [31:0] exp_addr = '0;
    logic        exp_err = 1'b0;
    bit          last_pending = 0;
    bit          done_expect = 0;
    bit          hold_valid = 0;
    logic [31:0] hold_addr, hold_data;
    int          done_count = 0;
    int          hold_cycles = 0;
    bit          ready_rand = 0;

    task automatic flush_model();
        exp_q.delete();
        gold_q.delete();
        exp_err      = 1'b0;
        last_pending = 0;
        done_expect  = 0;
        hold_valid   = 0;
    endtask

    always @(negedge clk) begin
        if (hold_cycles > 0) begin
            imem_ready = 1'b0;
            hold_cycles--;
        end else begin
            imem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: observe mid-cycle what the next rising edge will do
    always begin
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (rst_n) begin
            check_output("err_flag", err, exp_err);
            if (!busy) check_output("in_ready_idle", in_ready, 1'b0);
            if (done) done_count++;
            if (done_expect) begin
                check_output("done_timing", done, 1'b1);
                done_expect = 0;
            end
            if (hold_valid) begin
                check_output("bp_we_held", imem_we, 1'b1);
                check_output("bp_addr_held", imem_addr, hold_addr);
                check_output("bp_data_held", imem_wdata, hold_data);
                hold_valid = 0;
            end
            if (imem_we && !imem_ready) begin
                check_output("bp_in_ready", in_ready, 1'b0);
                hold_valid = 1;
                hold_addr  = imem_addr;
                hold_data  = imem_wdata;
            end
            if (imem_we && imem_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_write", imem_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("write_addr", imem_addr, e[63:32]);
                    check_output("write_data", imem_wdata, e[31:0]);
                    if (gold_q.size() > 0) begin
                        e = gold_q.pop_front();
                        check_output("vector_addr", imem_addr, e[63:32]);
                        check_output("vector_data", imem_wdata, e[31:0]);
                    end
                    if (exp_q.size() == 0 && last_pending) begin
                        done_expect  = 1;
                        last_pending = 0;
                    end
                end
            end
            if (start && !busy) begin
                exp_addr   = base_addr & 32'hFFFF_FFFC;
                exp_err    = 1'b0;
                done_count = 0;
            end
            if (in_valid && in_ready) begin
                if (mnem >= 28) begin
                    exp_err = 1'b1;
                end else begin
                    exp_q.push_back({exp_addr, ref_word(mnem, rs, rt, rd, shamt, imm, target)});
                    exp_addr = exp_addr + 32'd4;
                end
                if (in_last && exp_q.size() > 0) last_pending = 1;
            end
        end
    end

    task automatic start_prog(input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Presents one instruction and returns once it will be accepted at the next edge
    task automatic apply_stimulus(input int m, input int s, input int t, input int d, input int sh,
                                  input int im, input int tg, input bit last);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        mnem = 5'(m); rs = 5'(s); rt = 5'(t); rd = 5'(d); shamt = 5'(sh);
        imm = 16'(im); target = 26'(tg); in_last = last;
        #1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check_output("accept_timeout", in_ready, 1'b1);
    endtask

    task automatic end_inputs();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            @(negedge clk);
            #3;
            guard++;
        end while (busy && guard < 400);
        check_output("idle_reached", busy, 1'b0);
        check_output("done_pulses", done_count, 1);
        check_output("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        check_output("rst_we", imem_we, 1'b0);
        check_output("rst_addr", imem_addr, 32'd0);
        check_output("rst_wdata", imem_wdata, 32'd0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_err", err, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_in_ready", in_ready, 1'b0);
        #9 rst_n = 1'b1;

        start_prog(32'h0000_0400);
        gold_q.push_back({32'h0000_0400, 32'h012A_4020});
        apply_stimulus(7, 9, 10, 8, 0, 0, 0, 1);
        end_inputs();
        wait_idle();

        start_prog(32'h0000_0000);
        gold_q.push_back({32'h0000_0000, 32'h2008_0005});
        gold_q.push_back({32'h0000_0004, 32'h3C01_1234});
        gold_q.push_back({32'h0000_0008, 32'h0C10_0000});
        gold_q.push_back({32'h0000_000C, 32'h0003_1100});
        apply_stimulus(17, 0, 8, 0, 0, 5, 0, 0);
        apply_stimulus(23, 7, 1, 0, 0, 16'h1234, 0, 0);
        apply_stimulus(27, 0, 0, 0, 0, 0, 26'h010_0000, 0);
        apply_stimulus(0, 31, 3, 2, 4, 0, 0, 1);
        end_inputs();
        wait_idle();

        start_prog(32'h0000_0203);
        gold_q.push_back({32'h0000_0200, 32'h3443_BEEF});
        gold_q.push_back({32'h0000_0204, 32'h0022_1822});
        hold_cycles = 4;
        apply_stimulus(21, 2, 3, 0, 0, 16'hBEEF, 0, 0);
        apply_stimulus(8, 1, 2, 3, 0, 0, 0, 1);
        end_inputs();
        wait_idle();

        start_prog(32'h0000_0040);
        gold_q.push_back({32'h0000_0040, 32'h012A_4020});
        gold_q.push_back({32'h0000_0044, 32'h0085_3025});
        apply_stimulus(7, 9, 10, 8, 0, 0, 0, 0);
        apply_stimulus(30, 1, 1, 1, 1, 1, 1, 0);
        apply_stimulus(10, 4, 5, 6, 0, 0, 0, 1);
        end_inputs();
        wait_idle();
        check_output("err_sticky", err, 1'b1);
        start_prog(32'h0000_0000);
        #3;
        check_output("err_cleared", err, 1'b0);
        apply_stimulus(12, 1, 2, 3, 0, 0, 0, 1);
        end_inputs();
        wait_idle();

        start_prog(32'h0000_0100);
        hold_cycles = 1000;
        apply_stimulus(17, 1, 2, 0, 0, 7, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_output("pre_rst_we", imem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_rst_we", imem_we, 1'b0);
        check_output("async_rst_busy", busy, 1'b0);
        check_output("async_rst_addr", imem_addr, 32'd0);
        flush_model();
        @(negedge clk);
        hold_cycles = 0;
        rst_n = 1'b1;
        start_prog(32'h0000_0800);
        gold_q.push_back({32'h0000_0800, 32'h0022_1826});
        apply_stimulus(11, 1, 2, 3, 0, 0, 0, 1);
        end_inputs();
        wait_idle();

        for (int p = 0; p < 6; p++) begin
            int n;
            logic [31:0] b;
            ready_rand = (p % 2 == 1);
            b = (p == 2) ? 32'hFFFF_FFF4 : $urandom;
            n = $urandom_range(5, 25);
            start_prog(b);
            for (int i = 0; i < n; i++) begin
                int m;
                m = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 27);
                apply_stimulus(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                               $urandom_range(0, 31), $urandom_range(0, 65535),
                               $urandom_range(0, 26'h3FF_FFFF), (i == n - 1));
            end
            end_inputs();
            wait_idle();
        end
        ready_rand = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
